fpmul_result_buffer: RTL and testbench
======================================

FPMUL_RESULT_BUFFER -- requirements
Module: fpmul_result_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set FIFO entries; power of two, min 2.
REQ-002 Parameter CNT_W, default 16, SHALL set width of statistic counters.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL flag multiplier result on in_data as valid.
REQ-006 in_ready  output  1  SHALL flag buffer can accept a result this cycle.
REQ-007 in_data  input  32  SHALL carry IEEE-754 single-precision product.
REQ-008 out_valid  output  1  SHALL flag head entry presented on out_data/out_class.
REQ-009 out_ready  input  1  SHALL flag consumer takes head entry this cycle.
REQ-010 out_data  output  32  SHALL carry head entry product bits.
REQ-011 out_class  output  3  SHALL carry head entry class: 0 zero, 1 subnormal, 2 normal, 3 infinity, 4 qNaN, 5 sNaN.
REQ-012 count  output  clog2(DEPTH)+1  SHALL carry current occupancy.
REQ-013 state  output  2  SHALL carry FSM state: 0 EMPTY, 1 ACTIVE, 2 FULL.
REQ-014 total_cnt, inf_cnt, nan_cnt  output  CNT_W each  SHALL count accepted results, infinities, NaNs (q+s).

Function
REQ-015 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL be 1 iff state != FULL, driven from registered state only (no combinational path from out_ready).
REQ-017 out_valid SHALL be 1 iff state != EMPTY; out_data/out_class SHALL show head entry (first-word fall-through).
REQ-018 Latency push -> out_valid SHALL be exactly 1 cycle when buffer was EMPTY.
REQ-019 Class SHALL be computed from in_data at push and stored with the entry: exp==0 && frac==0 zero; exp==0 && frac!=0 subnormal; exp==255 && frac==0 infinity; exp==255 && frac[22]==1 qNaN; exp==255 && frac[22]==0 && frac!=0 sNaN; else normal; sign ignored.
REQ-020 Write/read pointers SHALL be clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
REQ-021 FSM: EMPTY->ACTIVE on push without pop; ACTIVE->FULL when push without pop at count DEPTH-1; ACTIVE->EMPTY when pop without push at count 1; FULL->ACTIVE on pop; otherwise hold.
REQ-022 Simultaneous push and pop in ACTIVE SHALL keep count and state unchanged, with FIFO order preserved.
REQ-023 In EMPTY a pop SHALL NOT occur; in FULL a push SHALL NOT occur (in_data ignored, no counter change).
REQ-024 total_cnt SHALL increment per push; inf_cnt per pushed infinity; nan_cnt per pushed qNaN or sNaN.
REQ-025 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 in_data SHALL be ignored (may be X) when in_valid=0; out_data SHALL be don't-care when out_valid=0.

Reset
REQ-027 rst low SHALL immediately, without clock: state=EMPTY, count=0, pointers=0, in_ready=1, out_valid=0, out_data=0, out_class=0, all counters 0.
REQ-028 Reset mid-operation SHALL discard all stored entries; no stale entry SHALL appear after release.
REQ-029 First push SHALL be possible on first rising edge with rst high.

Verification
REQ-030 Push 0x40400000 with out_ready=0 -> next cycle out_valid=1, out_data=0x40400000, out_class=2, count=1, state=ACTIVE, total_cnt=1.
REQ-031 Push 0x7F800000, 0x7FC00000, 0x7FA00000, 0x00000001 (DEPTH=4), out_ready=0 -> state=FULL, in_ready=0, inf_cnt=1, nan_cnt=2; pops return classes 3,4,5,1 in order.
REQ-032 FULL, in_valid=1 with 0x80000000 and out_ready=0 -> no push, count=4, total_cnt unchanged; then out_ready=1 one cycle -> count=3, in_ready=1.
REQ-033 count=2, in_valid=1 and out_ready=1 held 10 cycles with incrementing data -> count stays 2, outputs in push order across pointer wrap.
REQ-034 count=3 with rst pulsed low between edges -> outputs reach reset values before next edge; after release out_valid=0 until new push.
REQ-035 CNT_W=2, push 5 results -> total_cnt saturates at 3.

Source files
------------

// File: rtl/fpmul_result_buffer_if.sv
// Handshake bundle between a floating-point multiplier (producer), the result
// buffer and the downstream consumer.
interface fpmul_result_buffer_if;
    // Producer side
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;

    // Consumer side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_class;

    // Driver of the buffer (producer and consumer together)
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_class
    );

    // The buffer itself
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_class
    );
endinterface

// File: rtl/fpmul_result_buffer.sv
// Result buffer for a floating-point multiplier: a first-word fall-through FIFO
// that tags each single-precision product with its IEEE-754 class at push time
// and keeps saturating statistics on what it accepted.
module fpmul_result_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    fpmul_result_buffer_if.slave   bus,
    output logic [$clog2(DEPTH):0] count,
    output logic [1:0]             state,
    output logic [CNT_W-1:0]       total_cnt,
    output logic [CNT_W-1:0]       inf_cnt,
    output logic [CNT_W-1:0]       nan_cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = PtrW + 1;

    typedef enum logic [1:0] {
        StEmpty  = 2'd0,
        StActive = 2'd1,
        StFull   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ClsZero      = 3'd0,
        ClsSubnormal = 3'd1,
        ClsNormal    = 3'd2,
        ClsInf       = 3'd3,
        ClsQnan      = 3'd4,
        ClsSnan      = 3'd5
    } class_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]   count_q, count_d;
    logic [CNT_W-1:0]  total_cnt_q, total_cnt_d;
    logic [CNT_W-1:0]  inf_cnt_q, inf_cnt_d;
    logic [CNT_W-1:0]  nan_cnt_q, nan_cnt_d;

    // Entry storage carries no reset; stale words are never visible because
    // the read side is gated by the FSM state.
    logic [31:0]       data_mem [DEPTH];
    logic [2:0]        cls_mem  [DEPTH];

    logic              in_ready;
    logic              out_valid;
    logic              push;
    logic              pop;
    logic [7:0]        in_exp;
    logic [22:0]       in_frac;
    logic [2:0]        in_cls;

    // Handshake qualifiers; in_ready depends on registered state only.
    assign push = bus.in_valid && in_ready;
    assign pop  = out_valid && bus.out_ready;

    // Classify the incoming product; the sign bit plays no part.
    always_comb begin
        in_exp  = bus.in_data[30:23];
        in_frac = bus.in_data[22:0];
        in_cls  = ClsNormal;
        if (in_exp == 8'h00) begin
            in_cls = (in_frac == 23'd0) ? ClsZero : ClsSubnormal;
        end else if (in_exp == 8'hFF) begin
            if (in_frac == 23'd0) begin
                in_cls = ClsInf;
            end else if (in_frac[22]) begin
                in_cls = ClsQnan;
            end else begin
                in_cls = ClsSnan;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: occupancy-driven transitions; push+pop together holds.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (push && !pop && (count_q == OccW'(DEPTH - 1))) begin
                    state_d = StFull;
                end else if (pop && !push && (count_q == OccW'(1))) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    state_d = StActive;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // FSM outputs: handshake flags and the exported state code.
    always_comb begin
        in_ready  = (state_q != StFull);
        out_valid = (state_q != StEmpty);
        state     = state_q;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Pointer and occupancy next-state; pointers wrap DEPTH-1 -> 0.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + OccW'(1);
            2'b01:   count_d = count_q - OccW'(1);
            default: count_d = count_q;
        endcase
    end

    // Statistics next-state; every counter sticks at all-ones.
    always_comb begin
        total_cnt_d = total_cnt_q;
        inf_cnt_d   = inf_cnt_q;
        nan_cnt_d   = nan_cnt_q;
        if (push) begin
            if (total_cnt_q != {CNT_W{1'b1}}) begin
                total_cnt_d = total_cnt_q + CNT_W'(1);
            end
            if ((in_cls == ClsInf) && (inf_cnt_q != {CNT_W{1'b1}})) begin
                inf_cnt_d = inf_cnt_q + CNT_W'(1);
            end
            if (((in_cls == ClsQnan) || (in_cls == ClsSnan)) &&
                (nan_cnt_q != {CNT_W{1'b1}})) begin
                nan_cnt_d = nan_cnt_q + CNT_W'(1);
            end
        end
    end

    // Control and statistics registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            total_cnt_q <= '0;
            inf_cnt_q   <= '0;
            nan_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            total_cnt_q <= total_cnt_d;
            inf_cnt_q   <= inf_cnt_d;
            nan_cnt_q   <= nan_cnt_d;
        end
    end

    // Entry write: product and its class are stored together.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= bus.in_data;
            cls_mem[wr_ptr_q]  <= in_cls;
        end
    end

    // Head presentation; forced to zero while empty so reset shows clean values.
    always_comb begin
        bus.in_ready  = in_ready;
        bus.out_valid = out_valid;
        bus.out_data  = out_valid ? data_mem[rd_ptr_q] : 32'd0;
        bus.out_class = out_valid ? cls_mem[rd_ptr_q] : 3'd0;
        count         = count_q;
        total_cnt     = total_cnt_q;
        inf_cnt       = inf_cnt_q;
        nan_cnt       = nan_cnt_q;
    end

endmodule

// File: tb/tb_fpmul_result_buffer.sv
// Bench for fpmul_result_buffer: queue-based reference model checked every
// negative clock edge, plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_fpmul_result_buffer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpmul_result_buffer_if bus ();
    fpmul_result_buffer_if bus_s ();

    logic [2:0]       count;
    logic [1:0]       state;
    logic [CNT_W-1:0] total_cnt, inf_cnt, nan_cnt;

    logic [2:0]       count_s;
    logic [1:0]       state_s;
    logic [1:0]       total_s, inf_s, nan_s;

    fpmul_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .count     (count),
        .state     (state),
        .total_cnt (total_cnt),
        .inf_cnt   (inf_cnt),
        .nan_cnt   (nan_cnt)
    );

    fpmul_result_buffer #(.DEPTH(4), .CNT_W(2)) u_sat (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_s),
        .count     (count_s),
        .state     (state_s),
        .total_cnt (total_s),
        .inf_cnt   (inf_s),
        .nan_cnt   (nan_s)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq_data[$];
    int          mq_cls[$];
    int unsigned m_total = 0;
    int unsigned m_inf   = 0;
    int unsigned m_nan   = 0;

    function automatic int classify(input logic [31:0] d);
        logic [7:0]  e;
        logic [22:0] f;
        e = d[30:23];
        f = d[22:0];
        if (e == 8'd0)   return (f == 23'd0) ? 0 : 1;
        if (e == 8'd255) begin
            if (f == 23'd0) return 3;
            return f[22] ? 4 : 5;
        end
        return 2;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq_data.delete();
            mq_cls.delete();
            m_total = 0;
            m_inf   = 0;
            m_nan   = 0;
        end else begin : p_model
            bit do_push;
            bit do_pop;
            int c;
            do_push = bus.in_valid && (mq_data.size() < DEPTH);
            do_pop  = bus.out_ready && (mq_data.size() > 0);
            if (do_pop) begin
                void'(mq_data.pop_front());
                void'(mq_cls.pop_front());
            end
            if (do_push) begin
                c = classify(bus.in_data);
                mq_data.push_back(bus.in_data);
                mq_cls.push_back(c);
                if (m_total < CNT_MAX) m_total++;
                if (c == 3 && m_inf < CNT_MAX) m_inf++;
                if ((c == 4 || c == 5) && m_nan < CNT_MAX) m_nan++;
            end
        end
    end

    always @(negedge clk) begin : p_cmp
        int n;
        n = mq_data.size();
        chk("in_ready", bus.in_ready, n != DEPTH);
        chk("out_valid", bus.out_valid, n != 0);
        chk("count", count, n);
        chk("state", state, (n == 0) ? 0 : ((n == DEPTH) ? 2 : 1));
        chk("total_cnt", total_cnt, m_total);
        chk("inf_cnt", inf_cnt, m_inf);
        chk("nan_cnt", nan_cnt, m_nan);
        if (n != 0) begin
            chk("out_data", bus.out_data, mq_data[0]);
            chk("out_class", bus.out_class, mq_cls[0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hDEAD_BEEF;
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    logic [31:0] cls_vec_d [8] = '{32'h0000_0000, 32'hC000_0000, 32'hFF80_0000, 32'hFFFF_FFFF,
                                   32'h7F80_0001, 32'h807F_FFFF, 32'h0080_0000, 32'h7F7F_FFFF};
    int          cls_vec_c [8] = '{0, 2, 3, 4, 5, 1, 2, 2};

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_data     = 32'd0;
        bus.out_ready   = 1'b0;
        bus_s.in_valid  = 1'b0;
        bus_s.in_data   = 32'd0;
        bus_s.out_ready = 1'b0;

        // Asynchronous reset, observed before any clock edge.
        #1 rst = 1'b0;
        #2;
        chk("rst in_ready", bus.in_ready, 1);
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst out_data", bus.out_data, 0);
        chk("rst out_class", bus.out_class, 0);
        chk("rst count", count, 0);
        chk("rst state", state, 0);
        chk("rst total", total_cnt, 0);
        chk("rst inf", inf_cnt, 0);
        chk("rst nan", nan_cnt, 0);
        chk("rst sat total", total_s, 0);

        // Release between edges with a push already pending.
        @(negedge clk);
        #2;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h4040_0000;
        step();
        bus.in_valid = 1'b0;
        chk("first out_valid", bus.out_valid, 1);
        chk("first out_data", bus.out_data, 32'h4040_0000);
        chk("first out_class", bus.out_class, 2);
        chk("first count", count, 1);
        chk("first state", state, 1);
        chk("first total", total_cnt, 1);
        pop();
        chk("drain out_valid", bus.out_valid, 0);

        // Fill with special values.
        push(32'h7F80_0000);
        push(32'h7FC0_0000);
        push(32'h7FA0_0000);
        push(32'h0000_0001);
        chk("full state", state, 2);
        chk("full in_ready", bus.in_ready, 0);
        chk("full count", count, 4);
        chk("full inf", inf_cnt, 1);
        chk("full nan", nan_cnt, 2);
        chk("full total", total_cnt, 5);

        // Push attempt into a full buffer is dropped.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h8000_0000;
        step();
        chk("blocked count", count, 4);
        chk("blocked total", total_cnt, 5);
        chk("head class 0", bus.out_class, 3);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("pop full count", count, 3);
        chk("pop full in_ready", bus.in_ready, 1);
        chk("head class 1", bus.out_class, 4);
        pop();
        chk("head class 2", bus.out_class, 5);
        pop();
        chk("head class 3", bus.out_class, 1);
        pop();
        chk("empty again", bus.out_valid, 0);
        chk("total after drain", total_cnt, 5);

        // Classification table, one entry at a time.
        for (int i = 0; i < 8; i++) begin
            push(cls_vec_d[i]);
            chk("class table cls", bus.out_class, cls_vec_c[i]);
            chk("class table data", bus.out_data, cls_vec_d[i]);
            pop();
        end
        chk("table total", total_cnt, 13);
        chk("table inf", inf_cnt, 2);
        chk("table nan", nan_cnt, 4);

        // Steady streaming at count 2 across pointer wrap.
        push(32'h0000_0100);
        push(32'h0000_0101);
        chk("stream start count", count, 2);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 32'h0000_0102 + 32'(i);
            step();
            chk("stream count", count, 2);
            chk("stream head", bus.out_data, 32'h0000_0101 + 32'(i));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("stream total", total_cnt, 25);

        // Mid-operation reset at count 3.
        push(32'h0000_010C);
        chk("pre-reset count", count, 3);
        #2 rst = 1'b0;
        #1;
        chk("mid rst out_valid", bus.out_valid, 0);
        chk("mid rst in_ready", bus.in_ready, 1);
        chk("mid rst count", count, 0);
        chk("mid rst state", state, 0);
        chk("mid rst out_data", bus.out_data, 0);
        chk("mid rst out_class", bus.out_class, 0);
        chk("mid rst total", total_cnt, 0);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post rst idle", bus.out_valid, 0);
        end
        push(32'h3F80_0000);
        chk("post rst data", bus.out_data, 32'h3F80_0000);
        chk("post rst class", bus.out_class, 2);
        chk("post rst count", count, 1);
        chk("post rst total", total_cnt, 1);
        pop();

        // Saturation on the narrow-counter instance.
        bus_s.out_ready = 1'b1;
        bus_s.in_valid  = 1'b1;
        bus_s.in_data   = 32'h7F80_0000;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("sat total", total_s, (k < 3) ? k : 3);
            chk("sat inf", inf_s, (k < 3) ? k : 3);
            chk("sat count", count_s, 1);
        end
        bus_s.in_valid = 1'b0;
        step();
        chk("sat final total", total_s, 3);
        chk("sat nan", nan_s, 0);
        bus_s.out_ready = 1'b0;

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
